// File: rtl/hls_seq_pkg.sv
// hls_seq_pkg
//   Shared definitions for the HLS run sequencer: FSM state encoding,
//   result status codes and the packed result record width helper.
package hls_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRST,
    ST_START,
    ST_WAIT,
    ST_RECORD
  } seq_state_e;

  localparam int unsigned STATUS_W = 2;

  localparam logic [STATUS_W-1:0] STATUS_FAIL    = 2'b00;
  localparam logic [STATUS_W-1:0] STATUS_PASS    = 2'b01;
  localparam logic [STATUS_W-1:0] STATUS_NOCMP   = 2'b10;
  localparam logic [STATUS_W-1:0] STATUS_TIMEOUT = 2'b11;

  // Record layout: {status, run_idx, cycles}
  function automatic int unsigned rec_width(input int unsigned run_w,
                                            input int unsigned cycle_w);
    return STATUS_W + run_w + cycle_w;
  endfunction

endpackage

// File: rtl/hls_result_fifo.sv
// hls_result_fifo
//   Synchronous FIFO with registered head-of-queue outputs.
//   Ports:
//     clk_i, rst_ni      clock, synchronous active-low reset (flushes)
//     push_i/push_data_i write request/data; ignored while full_o=1
//     pop_i              consume head entry when valid_o=1
//     full_o, empty_o    registered occupancy flags
//     valid_o, data_o    registered head entry
module hls_result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    remain;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             push_ok, pop_ok;

  // Full blocks a push even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && valid_q;

  always_comb begin
    wptr_d  = wptr_q + AW'(push_ok);
    rptr_d  = rptr_q + AW'(pop_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    remain  = count_q - CW'(pop_ok);
    valid_d = (count_d != '0);
    full_d  = (count_d == CW'(DEPTH));
    data_d  = data_q;
    // Head register: bypass the write when the queue would otherwise be
    // empty, else preload the next stored entry.
    if (remain == '0) begin
      if (push_ok) begin
        data_d = push_data_i;
      end
    end else begin
      data_d = mem_q[rptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      data_q  <= data_d;
    end
  end

  assign full_o  = full_q;
  assign empty_o = !valid_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer
//   Runs a start_port/done_port accelerator a commanded number of times:
//   per run it resets the DUT, pulses start, counts cycles to done (or
//   timeout/abort) and queues a {status, run_idx, cycles} record.
//   Ports:
//     clock, reset               clock, synchronous active-low reset
//     cmd_valid/cmd_ready        sequence request handshake (ready in IDLE)
//     cmd_runs, cmd_compare      run count, use dut_success for status
//     abort                      ends the sequence after the current run
//     dut_reset, start_port      active-low DUT reset, one-cycle start
//     done_port, dut_success     DUT completion and self-check result
//     res_valid/res_ready/res_data  result record stream
//     busy, runs_done            not-IDLE flag, records pushed this sequence
module hls_run_sequencer
  import hls_seq_pkg::*;
#(
  parameter int unsigned RUN_W          = 16,
  parameter int unsigned CYCLE_W        = 32,
  parameter int unsigned TIMEOUT        = 200000000,
  parameter int unsigned DUT_RST_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [RUN_W-1:0]                  cmd_runs,
  input  logic                              cmd_compare,
  input  logic                              abort,
  output logic                              dut_reset,
  output logic                              start_port,
  input  logic                              done_port,
  input  logic                              dut_success,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [STATUS_W+RUN_W+CYCLE_W-1:0] res_data,
  output logic                              busy,
  output logic [RUN_W-1:0]                  runs_done
);

  localparam int unsigned REC_W  = rec_width(RUN_W, CYCLE_W);
  localparam int unsigned RSTC_W = (DUT_RST_CYCLES > 1) ? $clog2(DUT_RST_CYCLES) : 1;

  seq_state_e          state_q, state_d;
  logic [RUN_W-1:0]    runs_q, runs_d;
  logic                cmp_q, cmp_d;
  logic [RUN_W-1:0]    run_idx_q, run_idx_d;
  logic [RUN_W-1:0]    runs_done_q, runs_done_d;
  logic                abort_q, abort_d;
  logic [RSTC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CYCLE_W-1:0]  cnt_q, cnt_d;
  logic [STATUS_W-1:0] st_q, st_d;
  logic [CYCLE_W-1:0]  cyc_q, cyc_d;

  logic cmd_ready_q, dut_reset_q, start_port_q, busy_q;

  logic             push;
  logic [REC_W-1:0] push_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  always_comb begin
    state_d     = state_q;
    runs_d      = runs_q;
    cmp_d       = cmp_q;
    run_idx_d   = run_idx_q;
    runs_done_d = runs_done_q;
    abort_d     = abort_q;
    rst_cnt_d   = rst_cnt_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    cyc_d       = cyc_q;
    push        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          runs_d      = cmd_runs;
          cmp_d       = cmd_compare;
          run_idx_d   = '0;
          runs_done_d = '0;
          if (cmd_runs != '0) begin
            state_d   = ST_DRST;
            rst_cnt_d = '0;
          end
        end
      end
      ST_DRST: begin
        if (abort) abort_d = 1'b1;
        if (rst_cnt_q == RSTC_W'(DUT_RST_CYCLES - 1)) begin
          state_d = ST_START;
          cnt_d   = CYCLE_W'(1);
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_START: begin
        if (abort) abort_d = 1'b1;
        state_d = ST_WAIT;
        cnt_d   = cnt_q + 1'b1;
      end
      ST_WAIT: begin
        if (done_port) begin
          st_d    = cmp_q ? (dut_success ? STATUS_PASS : STATUS_FAIL) : STATUS_NOCMP;
          cyc_d   = cnt_q;
          state_d = ST_RECORD;
        end else if (abort) begin
          abort_d = 1'b1;
          st_d    = STATUS_TIMEOUT;
          cyc_d   = cnt_q;
          state_d = ST_RECORD;
        end else if (cnt_q >= CYCLE_W'(TIMEOUT)) begin
          st_d    = STATUS_TIMEOUT;
          cyc_d   = cnt_q;
          state_d = ST_RECORD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RECORD: begin
        if (abort) abort_d = 1'b1;
        if (!fifo_full) begin
          push        = 1'b1;
          run_idx_d   = run_idx_q + 1'b1;
          runs_done_d = runs_done_q + 1'b1;
          if ((run_idx_q + 1'b1) == runs_q || abort_q || abort) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DRST;
            rst_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign push_data = {st_q, run_idx_q, cyc_q};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      runs_q       <= '0;
      cmp_q        <= 1'b0;
      run_idx_q    <= '0;
      runs_done_q  <= '0;
      abort_q      <= 1'b0;
      rst_cnt_q    <= '0;
      cnt_q        <= '0;
      st_q         <= '0;
      cyc_q        <= '0;
      cmd_ready_q  <= 1'b0;
      dut_reset_q  <= 1'b0;
      start_port_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      runs_q       <= runs_d;
      cmp_q        <= cmp_d;
      run_idx_q    <= run_idx_d;
      runs_done_q  <= runs_done_d;
      abort_q      <= abort_d;
      rst_cnt_q    <= rst_cnt_d;
      cnt_q        <= cnt_d;
      st_q         <= st_d;
      cyc_q        <= cyc_d;
      // Output flops decode the next state so they align with state_q.
      cmd_ready_q  <= (state_d == ST_IDLE);
      dut_reset_q  <= (state_d != ST_DRST);
      start_port_q <= (state_d == ST_START);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign fifo_pop = res_ready && !fifo_empty;

  hls_result_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .valid_o     (res_valid),
    .data_o      (res_data)
  );

  assign cmd_ready  = cmd_ready_q;
  assign dut_reset  = dut_reset_q;
  assign start_port = start_port_q;
  assign busy       = busy_q;
  assign runs_done  = runs_done_q;

endmodule

// File: tb/tb_hls_run_sequencer.sv
module tb_hls_run_sequencer;

  localparam int RUN_W   = 16;
  localparam int CYCLE_W = 32;
  localparam int TMO     = 50;
  localparam int RSTC    = 2;
  localparam int DEPTH   = 2;
  localparam int REC_W   = 2 + RUN_W + CYCLE_W;

  logic               clock;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [RUN_W-1:0]   cmd_runs;
  logic               cmd_compare;
  logic               abort;
  logic               dut_reset;
  logic               start_port;
  logic               done_port;
  logic               dut_success;
  logic               res_valid;
  logic               res_ready;
  logic [REC_W-1:0]   res_data;
  logic               busy;
  logic [RUN_W-1:0]   runs_done;

  hls_run_sequencer #(
    .RUN_W          (RUN_W),
    .CYCLE_W        (CYCLE_W),
    .TIMEOUT        (TMO),
    .DUT_RST_CYCLES (RSTC),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_runs    (cmd_runs),
    .cmd_compare (cmd_compare),
    .abort       (abort),
    .dut_reset   (dut_reset),
    .start_port  (start_port),
    .done_port   (done_port),
    .dut_success (dut_success),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .runs_done   (runs_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_q[$];

  // Accelerator model configuration (owned by stimulus)
  int   done_delay  = 10;
  int   abort_k     = 0;
  int   abort_start = 0;
  logic succ        = 1'b1;
  // Owned by the model
  int   start_total;

  function automatic logic [REC_W-1:0] mkrec(input logic [1:0] st, input int idx, input int cyc);
    return {st, 16'(idx), 32'(cyc)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Accelerator model: done_port done_delay cycles after the start cycle.
  initial begin : model
    int k;
    int cur;
    logic active;
    done_port   = 1'b0;
    abort       = 1'b0;
    dut_success = 1'b0;
    start_total = 0;
    k = 0;
    cur = 0;
    active = 1'b0;
    forever begin
      @(negedge clock);
      done_port   = 1'b0;
      abort       = 1'b0;
      dut_success = succ;
      if (!reset || !dut_reset) begin
        active = 1'b0;
      end else if (start_port) begin
        start_total++;
        cur = start_total;
        k = 0;
        active = 1'b1;
      end else if (active) begin
        k++;
        if (abort_k != 0 && k == abort_k && cur == abort_start) begin
          abort  = 1'b1;
          active = 1'b0;
        end else if (done_delay != 0 && k == done_delay) begin
          done_port = 1'b1;
          active    = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pop/compare, hold stability, reset length before start.
  logic             hold;
  logic [REC_W-1:0] hold_data;
  int               rst_low;
  initial begin
    hold = 1'b0;
    hold_data = '0;
    rst_low = 0;
  end

  always @(negedge clock) begin : monitor
    logic [REC_W-1:0] e;
    if (!reset) begin
      hold    = 1'b0;
      rst_low = 0;
    end else begin
      if (start_port) check("dut_reset_low_cycles", 64'(rst_low), 64'(RSTC));
      if (hold && res_valid) check("res_data_stable", 64'(res_data), 64'(hold_data));
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_record: got st=%b idx=%0d cyc=%0d with none expected",
                   res_data[REC_W-1 -: 2], res_data[CYCLE_W +: RUN_W], res_data[CYCLE_W-1:0]);
        end else begin
          e = exp_q.pop_front();
          if (res_data !== e) begin
            errors++;
            $display("FAIL record: got st=%b idx=%0d cyc=%0d expected st=%b idx=%0d cyc=%0d",
                     res_data[REC_W-1 -: 2], res_data[CYCLE_W +: RUN_W], res_data[CYCLE_W-1:0],
                     e[REC_W-1 -: 2], e[CYCLE_W +: RUN_W], e[CYCLE_W-1:0]);
          end
        end
      end
      hold      = res_valid && !res_ready;
      hold_data = res_data;
      rst_low   = dut_reset ? 0 : rst_low + 1;
    end
  end

  task automatic issue(input int runs, input logic cmp);
    int n;
    @(negedge clock);
    cmd_runs    = 16'(runs);
    cmd_compare = cmp;
    cmd_valid   = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 200 cycles");
    end
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && cmd_ready && !busy && !res_valid) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_idle: got %0d records pending expected 0 within 3000 cycles", name, exp_q.size());
    end
  endtask

  initial begin : stim
    int s0;
    int n;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_runs    = '0;
    cmd_compare = 1'b0;
    res_ready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_cmd_ready", 64'(cmd_ready), 0);
    check("rst_dut_reset", 64'(dut_reset), 0);
    check("rst_start_port", 64'(start_port), 0);
    check("rst_res_valid", 64'(res_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_runs_done", 64'(runs_done), 0);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_cmd_ready", 64'(cmd_ready), 1);
    check("post_rst_dut_reset", 64'(dut_reset), 1);

    // Normal runs: 3 passes of 11 cycles
    done_delay = 10; succ = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(mkrec(2'b01, i, 11));
    issue(3, 1'b1);
    check("normal_busy", 64'(busy), 1);
    check("normal_cmd_ready", 64'(cmd_ready), 0);
    check("normal_dut_reset_low", 64'(dut_reset), 0);
    wait_idle("normal");
    check("normal_runs_done", 64'(runs_done), 3);

    // Zero runs: nothing started, nothing recorded
    s0 = start_total;
    issue(0, 1'b1);
    check("zero_cmd_ready", 64'(cmd_ready), 1);
    check("zero_busy", 64'(busy), 0);
    repeat (6) @(negedge clock);
    check("zero_no_start", 64'(start_total), 64'(s0));
    check("zero_no_result", 64'(res_valid), 0);
    check("zero_runs_done", 64'(runs_done), 0);

    // Failing self-check
    done_delay = 5; succ = 1'b0;
    exp_q.push_back(mkrec(2'b00, 0, 6));
    issue(1, 1'b1);
    wait_idle("fail");
    succ = 1'b1;

    // Timeout: never done, two runs
    done_delay = 0;
    exp_q.push_back(mkrec(2'b11, 0, TMO));
    exp_q.push_back(mkrec(2'b11, 1, TMO));
    issue(2, 1'b1);
    wait_idle("timeout");
    check("timeout_runs_done", 64'(runs_done), 2);

    // Done and timeout in the same cycle: done wins
    done_delay = TMO - 1;
    exp_q.push_back(mkrec(2'b01, 0, TMO));
    issue(1, 1'b1);
    wait_idle("done_vs_timeout");

    // Backpressure: depth 2, consumer stalled, 4 runs
    done_delay = 10;
    res_ready  = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(mkrec(2'b01, i, 11));
    issue(4, 1'b1);
    repeat (80) @(negedge clock);
    check("bp_busy", 64'(busy), 1);
    check("bp_res_valid", 64'(res_valid), 1);
    check("bp_runs_done", 64'(runs_done), 2);
    check("bp_cmd_ready", 64'(cmd_ready), 0);
    res_ready = 1'b1;
    wait_idle("backpressure");
    check("bp_final_runs_done", 64'(runs_done), 4);

    // Abort at count 7 of run 1 of 5
    done_delay  = 10;
    abort_k     = 6;
    abort_start = start_total + 2;
    exp_q.push_back(mkrec(2'b01, 0, 11));
    exp_q.push_back(mkrec(2'b11, 1, 7));
    issue(5, 1'b1);
    wait_idle("abort");
    check("abort_runs_done", 64'(runs_done), 2);
    abort_k = 0;

    // Reset during WAIT, then a no-compare run
    s0 = start_total;
    issue(2, 1'b1);
    n = 0;
    while (start_total == s0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("mid_reset_started", 64'(start_total > s0), 1);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mid_reset_res_valid", 64'(res_valid), 0);
    check("mid_reset_start_port", 64'(start_port), 0);
    check("mid_reset_dut_reset", 64'(dut_reset), 0);
    check("mid_reset_busy", 64'(busy), 0);
    check("mid_reset_runs_done", 64'(runs_done), 0);
    reset = 1'b1;
    @(negedge clock);
    exp_q.push_back(mkrec(2'b10, 0, 11));
    issue(1, 1'b0);
    wait_idle("nocmp");
    check("nocmp_runs_done", 64'(runs_done), 1);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hls_run_sequencer.md
# hls_run_sequencer

Synthesizable run controller that drives one Bambu-generated accelerator top (`start_port`/`done_port` handshake) through a commanded number of back-to-back executions. For each run it:

- resets the DUT;
- pulses `start_port`;
- counts cycles until `done_port`, or until a timeout;
- pushes a status/run-index/cycle-count record into a result FIFO.

It replaces the simulation-only run/measure loop with on-chip logic for FPGA characterisation of the benchmark kernels.

## Interface
Parameters:
- `RUN_W`, 16: width of run count and run index.
- `CYCLE_W`, 32: width of the cycle counter.
- `TIMEOUT`, 200000000: maximum counted cycles per run; must be < 2^CYCLE_W.
- `DUT_RST_CYCLES`, 2: cycles `dut_reset` is held low before each start; ≥1.
- `FIFO_DEPTH`, 8: result FIFO entries, power of two.

Ports (reset is synchronous and active-low, sampled on the rising edge of `clock`):
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-low.
- `cmd_valid`  in  1  sequence request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_runs`  in  RUN_W  number of runs; 0 is legal.
- `cmd_compare`  in  1  when 1, `dut_success` is used for pass/fail.
- `abort`  in  1  terminates the sequence.
- `dut_reset`  out  1  active-low reset to the DUT.
- `start_port`  out  1  one-cycle start pulse.
- `done_port`  in  1  DUT completion.
- `dut_success`  in  1  DUT self-check result, sampled with `done_port`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed.
- `res_data`  out  2+RUN_W+CYCLE_W  {status[1:0], run_idx, cycles}.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `runs_done`  out  RUN_W  results recorded in the current sequence.

## Operation
Status codes:
- 2'b01 PASS
- 2'b00 FAIL
- 2'b10 NOCMP (`cmd_compare`=0)
- 2'b11 TIMEOUT/ABORT

FSM states: IDLE, DRST, START, WAIT, RECORD.
- **IDLE:** `cmd_valid` && `cmd_ready` latches `cmd_runs`/`cmd_compare`, clears `runs_done` and `run_idx`.
  - `cmd_runs`=0 → stay IDLE; nothing is recorded.
  - Otherwise → DRST.
- **DRST:** `dut_reset`=0 for exactly `DUT_RST_CYCLES` cycles, then → START. `done_port` is ignored.
- **START:** `start_port`=1 for this cycle only; counter loaded with 1 → WAIT.
- **WAIT:** counter increments each cycle. Exit conditions, in priority order:
  - `done_port`=1 → status PASS/FAIL from `dut_success`, or NOCMP; cycles = counter value in the done cycle.
  - `abort`=1 → status TIMEOUT; cycles = current value.
  - counter == `TIMEOUT` → status TIMEOUT; cycles = `TIMEOUT`.
  - All three exits go to RECORD.
- **RECORD:** push a record if the FIFO is not full, otherwise stall with all fields frozen. On push: `run_idx`++, `runs_done`++.
  - If `run_idx`+1 == runs, or an abort is latched → IDLE.
  - Otherwise → DRST.
- `abort` in DRST/START is latched. The current run still completes its WAIT exit and record, then the sequence ends.
- Result FIFO:
  - Push is blocked when full, even if a pop occurs in the same cycle.
  - Pop happens when `res_valid` && `res_ready`.
  - `res_data` is stable while `res_valid`=1 && `res_ready`=0.

## Timing
- Reset values:
  - `cmd_ready`=0, `dut_reset`=0, `start_port`=0, `res_valid`=0, `busy`=0, `runs_done`=0.
  - FIFO empty; FSM enters IDLE; `cmd_ready`=1 in the first cycle after `reset` deasserts.
- Reset mid-run: all state cleared within one cycle; the FIFO is flushed; `dut_reset` is driven low.
- Command accept → first `dut_reset` low cycle: 1 cycle.
- Cycle counting: `done_port` high in the cycle after START gives cycles=2. The START cycle counts as 1.
- `done_port` and timeout in the same cycle: done wins.
- RECORD push → record visible at `res_valid`: 1 cycle.
- Consecutive runs are separated by 1 (RECORD) + `DUT_RST_CYCLES` cycles.
- All outputs are registered.

## Structure
- Package `hls_seq_pkg`: FSM state enum, status code constants, result record packing widths.
- Sub-module `hls_result_fifo`: synchronous FIFO, parameters WIDTH and DEPTH, registered outputs, full/empty flags.
- Sequencer FSM and counters live in `hls_run_sequencer`.

## Test plan
- **Normal runs:** `cmd_runs`=3, `cmd_compare`=1; DUT model asserts `done_port` 10 cycles after each start with `dut_success`=1 → three records {01, idx 0..2, cycles=11}. Each run is preceded by 2 `dut_reset`-low cycles.
- **Timeout:** TIMEOUT=50, DUT never done → record {11, 0, 50}, then the next run starts with DRST. `done_port` and timeout both at count 50 → record {01, 0, 50}.
- **Backpressure:** FIFO_DEPTH=2, `res_ready`=0, `cmd_runs`=4 → FSM stalls in RECORD after 2 results, `busy`=1. Releasing `res_ready` drains all 4 records in order with no loss.
- **Edge commands:** `cmd_runs`=0 → no `start_port`, no result, `cmd_ready` returns high next cycle. `cmd_compare`=0 → status 10.
- **Abort:** abort asserted in WAIT at count 7 of run 1 of 5 → record {11, 1, 7}; sequence ends with `runs_done`=2.
- **Reset mid-run:** `reset` low during WAIT → next cycle `res_valid`=0, `start_port`=0, `dut_reset`=0; after release, a new command behaves normally.
